// File: rtl/controller_pkg.sv
// controller_pkg: shared definitions for the gamepad scan controller.
//   - button bit indices of buttonsOut (BTN_UP .. BTN_Z)
//   - scan phase state enum (IDLE, P0..P7)
//   - default phase length in clocks
package controller_pkg;

  localparam int PHASE_CYCLES_DEF = 500;  // 10 us at 50 MHz
  localparam int NUM_BTNS         = 11;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;

  // Encoding is sequential so the next phase is state + 1.
  typedef enum logic [3:0] {
    IDLE, P0, P1, P2, P3, P4, P5, P6, P7
  } phase_e;

endpackage

// File: rtl/controller_if.sv
// controller_if: pad connector + game-side signals of the scan controller.
//   pad lines (active-high): up_z, down_y, left_x, right, a_b, start_c
//   vga_vs       : vertical sync, asynchronous to clk
//   selectSignal : pad select line driven by the controller
//   buttonsOut   : registered 11-bit button vector (1 = pressed)
// modport slave  : the controller side
// modport master : the board / pad side
interface controller_if;

  logic                               up_z;
  logic                               down_y;
  logic                               left_x;
  logic                               right;
  logic                               a_b;
  logic                               start_c;
  logic                               vga_vs;
  logic                               selectSignal;
  logic [controller_pkg::NUM_BTNS-1:0] buttonsOut;

  modport slave (
    input  up_z, down_y, left_x, right, a_b, start_c, vga_vs,
    output selectSignal, buttonsOut
  );

  modport master (
    output up_z, down_y, left_x, right, a_b, start_c, vga_vs,
    input  selectSignal, buttonsOut
  );

endinterface

// File: rtl/controller_vs_edge.sv
// controller_vs_edge: 2-FF synchronizer for the asynchronous vertical sync
// followed by a rising-edge detector.
//   clk, reset : system clock, synchronous active-high reset
//   vs_async   : raw vertical sync
//   vs_rise    : one-clock pulse on a synchronized rising edge
module controller_vs_edge (
  input  logic clk,
  input  logic reset,
  input  logic vs_async,
  output logic vs_rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], vs_async};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign vs_rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/controller.sv
// controller: once per video frame, walks a Genesis-style pad through its
// multiplexed select sequence, samples the pad lines at the end of each
// phase into shadow registers and publishes them atomically on buttonsOut.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : controller_if.slave (pad lines, vga_vs, selectSignal,
//                buttonsOut)
// Build option CONTROLLER_SIX_BUTTON_EN: full P0..P7 scan with X/Y/Z.
// Without it the scan is P0, P1 only and buttonsOut[10:8] stays 0.
module controller
  import controller_pkg::*;
#(
  parameter int PHASE_CYCLES = PHASE_CYCLES_DEF
) (
  input logic         clk,
  input logic         reset,
  controller_if.slave bus
);

  localparam int             CW       = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PHASE_CYCLES - 1);
`ifdef CONTROLLER_SIX_BUTTON_EN
  localparam phase_e LAST_PHASE = P7;
`else
  localparam phase_e LAST_PHASE = P1;
`endif

  phase_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic [NUM_BTNS-1:0]   shadow_q, shadow_d;
  logic [NUM_BTNS-1:0]   btn_q, btn_d;
`ifdef CONTROLLER_SIX_BUTTON_EN
  logic                  six_q, six_d;
`endif
  logic                  vs_rise;
  logic                  phase_end;

  controller_vs_edge u_vs_edge (
    .clk      (clk),
    .reset    (reset),
    .vs_async (bus.vga_vs),
    .vs_rise  (vs_rise)
  );

  // Last clock of the current phase: the pad has had PHASE_CYCLES-1 clocks
  // to settle since select changed.
  assign phase_end = (state_q != IDLE) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    btn_d    = btn_q;
`ifdef CONTROLLER_SIX_BUTTON_EN
    six_d    = six_q;
`endif
    if (state_q == IDLE) begin
      // vs edges are only honoured here; mid-scan edges are dropped.
      if (vs_rise) begin
        state_d = P0;
        cnt_d   = '0;
        sel_d   = 1'b0;
`ifdef CONTROLLER_SIX_BUTTON_EN
        six_d   = 1'b0;
`endif
      end
    end else if (!phase_end) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        P0: begin
          shadow_d[BTN_UP]    = bus.up_z;
          shadow_d[BTN_DOWN]  = bus.down_y;
          shadow_d[BTN_A]     = bus.a_b;
          shadow_d[BTN_START] = bus.start_c;
        end
        P1: begin
          // Overwrites the P0 up/down samples on purpose.
          shadow_d[BTN_UP]    = bus.up_z;
          shadow_d[BTN_DOWN]  = bus.down_y;
          shadow_d[BTN_LEFT]  = bus.left_x;
          shadow_d[BTN_RIGHT] = bus.right;
          shadow_d[BTN_B]     = bus.a_b;
          shadow_d[BTN_C]     = bus.start_c;
        end
`ifdef CONTROLLER_SIX_BUTTON_EN
        // A 6-button pad reports all four d-pad lines active in the third
        // low-select phase; a 3-button pad cannot.
        P4: six_d = bus.up_z & bus.down_y & bus.left_x & bus.right;
        P5: begin
          shadow_d[BTN_Z] = six_q & bus.up_z;
          shadow_d[BTN_Y] = six_q & bus.down_y;
          shadow_d[BTN_X] = six_q & bus.left_x;
        end
`endif
        default: ;
      endcase
      if (state_q == LAST_PHASE) begin
        state_d = IDLE;
        sel_d   = 1'b1;
        btn_d   = shadow_d;  // includes the sample taken on this clock
`ifndef CONTROLLER_SIX_BUTTON_EN
        btn_d[BTN_Z:BTN_X] = '0;
`endif
      end else begin
        state_d = phase_e'(state_q + 4'd1);
        sel_d   = ~sel_q;    // even phases low, odd phases high
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b1;
      shadow_q <= '0;
      btn_q    <= '0;
`ifdef CONTROLLER_SIX_BUTTON_EN
      six_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      btn_q    <= btn_d;
`ifdef CONTROLLER_SIX_BUTTON_EN
      six_q    <= six_d;
`endif
    end
  end

  assign bus.selectSignal = sel_q;
  assign bus.buttonsOut   = btn_q;

endmodule

// File: tb/tb_controller.sv
// tb_controller: directed + randomized scans of controller against a pad
// model that reacts to select transitions and a button-level expectation.
module tb_controller;
  import controller_pkg::*;

  localparam int PC = 8;
`ifdef CONTROLLER_SIX_BUTTON_EN
  localparam int NPH    = 8;
  localparam int RST_AT = 3 * PC + 2;
`else
  localparam int NPH    = 2;
  localparam int RST_AT = PC + 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controller_if bus ();

  controller #(.PHASE_CYCLES(PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // pad model state
  logic          model_en = 1'b0;
  logic          six_pad  = 1'b0;
  logic [10:0]   press    = '0;
  logic [1:0]    noise    = '0;
  logic [5:0]    d_lines  = '0;  // direct drive: up_z,down_y,left_x,right,a_b,start_c
  logic [10:0]   prev_btn = '0;
  int            tgl = 0, arm_gen = 0, seen_gen = 0, ph;

  // Select transitions since the scan was armed: phase index = tgl - 1.
  always @(bus.selectSignal) begin
    if (seen_gen != arm_gen) begin
      seen_gen = arm_gen;
      tgl      = 0;
    end
    tgl = tgl + 1;
  end

  always_comb begin
    ph          = tgl - 1;
    bus.up_z    = d_lines[0];
    bus.down_y  = d_lines[1];
    bus.left_x  = d_lines[2];
    bus.right   = d_lines[3];
    bus.a_b     = d_lines[4];
    bus.start_c = d_lines[5];
    if (model_en) begin
      if (!bus.selectSignal) begin
        bus.a_b     = press[BTN_A];
        bus.start_c = press[BTN_START];
        if (six_pad && ph == 4) begin
          {bus.up_z, bus.down_y, bus.left_x, bus.right} = 4'hF;
        end else begin
          bus.up_z    = press[BTN_UP];
          bus.down_y  = press[BTN_DOWN];
          bus.left_x  = (ph == 4) ? 1'b0 : noise[0];
          bus.right   = (ph == 4) ? 1'b0 : noise[1];
        end
      end else begin
        bus.a_b     = press[BTN_B];
        bus.start_c = press[BTN_C];
        if (six_pad && ph == 5) begin
          bus.up_z   = press[BTN_Z];
          bus.down_y = press[BTN_Y];
          bus.left_x = press[BTN_X];
          bus.right  = noise[0];  // Mode line, must be ignored
        end else begin
          bus.up_z   = press[BTN_UP];
          bus.down_y = press[BTN_DOWN];
          bus.left_x = press[BTN_LEFT];
          bus.right  = press[BTN_RIGHT];
        end
      end
    end
  end

  // What the game should see for a given set of held buttons.
  function automatic logic [10:0] expect_btn(input logic [10:0] p, input bit six);
    logic [10:0] e;
    e = p;
`ifndef CONTROLLER_SIX_BUTTON_EN
    six = 1'b0;
`endif
    if (!six) e[10:8] = 3'b000;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_scan(input string tag);
    int k;
    arm_gen++;
    noise = 2'($urandom);
    @(negedge clk);
    bus.vga_vs = 1'b1;
    k = 0;
    while (bus.selectSignal !== 1'b0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    bus.vga_vs = 1'b0;
    chk({tag, "_lat"}, 32'(k >= 3 && k <= 4), 32'd1);
  endtask

  // Runs one scan and checks select timing, update instant and final value.
  task automatic run_scan(input string tag, input logic [10:0] exp, input bit mid_vs);
    int sel_err, btn_err;
    logic exp_sel;
    logic [10:0] eb;
    sel_err = 0;
    btn_err = 0;
    start_scan(tag);
    for (int n = 0; n < (NPH + 3) * PC; n++) begin
      exp_sel = (n < NPH * PC) ? 1'((n / PC) % 2) : 1'b1;
      eb      = (n < NPH * PC) ? prev_btn : exp;
      if (bus.selectSignal !== exp_sel) sel_err++;
      if (bus.buttonsOut !== eb) btn_err++;
      if (mid_vs && n == PC + 1) bus.vga_vs = 1'b1;
      if (mid_vs && n == PC + 4) bus.vga_vs = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_sel"}, 32'(sel_err), 32'd0);
    chk({tag, "_upd"}, 32'(btn_err), 32'd0);
    chk({tag, "_btn"}, 32'(bus.buttonsOut), 32'(exp));
    prev_btn = exp;
  endtask

  initial begin
    int err;
    logic [10:0] p;
    bit s;
    reset      = 1'b1;
    bus.vga_vs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(bus.selectSignal), 32'd1);
    chk("rst_btn", 32'(bus.buttonsOut), 32'd0);
    reset = 1'b0;

    // Idle with no vs edge: lines wiggle, nothing may change.
    err = 0;
    for (int i = 0; i < 60; i++) begin
      d_lines = 6'($urandom);
      @(negedge clk);
      if (bus.selectSignal !== 1'b1 || bus.buttonsOut !== 11'd0) err++;
    end
    chk("idle_quiet", 32'(err), 32'd0);

    // Only up_z held on the raw lines.
    d_lines = 6'b000001;
    run_scan("up_only", 11'h001, 1'b0);

    // 3-button pad: A, C, right.
    model_en = 1'b1;
    six_pad  = 1'b0;
    press    = '0;
    press[BTN_A] = 1'b1; press[BTN_C] = 1'b1; press[BTN_RIGHT] = 1'b1;
    run_scan("acr", 11'h058, 1'b0);

    // X and Z on a 6-button pad, then the same presses on a 3-button pad.
    press = '0;
    press[BTN_X] = 1'b1; press[BTN_Z] = 1'b1;
    six_pad = 1'b1;
    run_scan("xz_six", expect_btn(press, 1'b1), 1'b0);
    six_pad = 1'b0;
    run_scan("xz_three", expect_btn(press, 1'b0), 1'b0);

    // All of X/Y/Z plus Start on a 6-button pad, with a mid-scan vs edge.
    press = '0;
    press[BTN_X] = 1'b1; press[BTN_Y] = 1'b1; press[BTN_Z] = 1'b1; press[BTN_START] = 1'b1;
    six_pad = 1'b1;
    run_scan("xyz_midvs", expect_btn(press, 1'b1), 1'b1);

    // Reset in the middle of a scan.
    press = 11'h7FF;
    start_scan("rst_mid");
    repeat (RST_AT) @(negedge clk);
    chk("rst_mid_pre", 32'(bus.buttonsOut), 32'(prev_btn));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_sel", 32'(bus.selectSignal), 32'd1);
    chk("rst_mid_btn", 32'(bus.buttonsOut), 32'd0);
    reset = 1'b0;
    err = 0;
    repeat ((NPH + 2) * PC) begin
      @(negedge clk);
      if (bus.selectSignal !== 1'b1 || bus.buttonsOut !== 11'd0) err++;
    end
    chk("rst_mid_quiet", 32'(err), 32'd0);
    prev_btn = '0;

    // Random pads and presses.
    for (int i = 0; i < 10; i++) begin
      p       = 11'($urandom);
      s       = 1'($urandom);
      press   = p;
      six_pad = s;
      run_scan($sformatf("rnd%0d", i), expect_btn(p, s), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller.md
# controller

Reads a Sega Genesis/Mega Drive-style 3- or 6-button gamepad once per video frame by driving the pad's select line through the standard multiplexed read sequence. Samples the shared pad lines in each select phase and publishes a stable 11-bit active-high button vector. Sits between the board-level pad connector (lines already inverted to active-high) and the game logic, and is paced by the VGA vertical sync.

## Interface
- PHASE_CYCLES, default 500: clocks per select phase (10 µs at 50 MHz); minimum 2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- up_z  input  1  pad line: Up, or Z in the 6-button extended phase; 1 = pressed.
- down_y  input  1  pad line: Down / Y; 1 = pressed.
- left_x  input  1  pad line: Left / X; 1 = pressed.
- right  input  1  pad line: Right (Mode in the extended phase, ignored); 1 = pressed.
- a_b  input  1  pad line: A when select low, B when select high; 1 = pressed.
- start_c  input  1  pad line: Start when select low, C when select high; 1 = pressed.
- vga_vs  input  1  VGA vertical sync, asynchronous to clk; a rising edge starts a scan.
- selectSignal  output  1  pad select line; idles high.
- buttonsOut  output  11  registered button state, 1 = pressed: [0] up, [1] down, [2] left, [3] right, [4] A, [5] B, [6] C, [7] start, [8] X, [9] Y, [10] Z.

## Operation
- vga_vs passes through a 2-FF synchronizer, then a rising-edge detector.
- States: IDLE, P0..P7. Every phase lasts exactly PHASE_CYCLES clocks.
- selectSignal is 0 in even phases and 1 in odd phases and IDLE.
- IDLE -> P0 on a detected vs edge. Pn -> Pn+1 when the phase counter expires. P7 -> IDLE, and buttonsOut is updated in that same transition.
- Each phase samples its lines on its last clock, into shadow registers:
  - P0: up, down, A (a_b), start (start_c).
  - P1: up, down, left, right, B (a_b), C (start_c).
  - P4: six-button flag = up_z & down_y & left_x & right.
  - P5: if the flag is set, Z = up_z, Y = down_y, X = left_x; otherwise X/Y/Z = 0.
- Up/down values sampled in P1 take precedence over those from P0.
- buttonsOut loads all 11 shadow bits atomically; it never shows a partial scan.
- vs edges arriving outside IDLE are ignored, with no queuing.
- The shadow six-button flag is cleared at P0 of each scan.

## Timing
- Reset: state IDLE, selectSignal = 1, buttonsOut = 0, shadows and counter = 0, synchronizer cleared. Reset mid-scan aborts the scan; buttonsOut is not updated.
- A raw vga_vs rise reaches the edge detector after 2-3 clocks. P0 starts on the next clock.
- selectSignal changes on the first clock of each phase, so pad lines get PHASE_CYCLES-1 clocks to settle before sampling.
- Full scan: 8*PHASE_CYCLES clocks. buttonsOut is valid the clock after P7 ends.
- Updates occur at most once per frame, which meets the 6-button >1.5 ms inter-scan reset gap at 60 Hz.

## Configuration
- CONTROLLER_SIX_BUTTON_EN defined: the full P0..P7 sequence, with X/Y/Z as described above.
- Not defined:
  - The scan is P0, P1 only, then IDLE; buttonsOut updates at the end of P1.
  - buttonsOut[10:8] are tied to 0.
  - The P4/P5 logic is removed.

## Structure
- Package controller_pkg holds:
  - the button bit-index localparams (BTN_UP .. BTN_Z);
  - the phase state enum;
  - the default PHASE_CYCLES.
- One sub-module, controller_vs_edge: the 2-FF synchronizer plus rising-edge pulse.
- Phase FSM, counter and sampling stay in controller.

## Test plan
- Reset held, then released with no vs edge -> selectSignal = 1 and buttonsOut = 0 indefinitely.
- vs pulse with up_z = 1 and all other lines 0 -> after one full scan, buttonsOut = 11'b000_0000_0001.
- vs edge with a model pad (drives lines per selectSignal phase; presses A, C, right) -> buttonsOut = 11'b000_0101_1000. selectSignal shows 8 phases of PHASE_CYCLES each.
- 6-button model pad with X and Z pressed (all four d-pad lines = 1 in P4, X/Z in P5) -> buttonsOut[10:8] = 3'b101. With a 3-button model (P4 lines 0), the same presses give buttonsOut[10:8] = 0.
- Second vs edge mid-scan -> ignored; exactly one buttonsOut update per scan. Reset asserted during P3 -> selectSignal = 1 next clock, buttonsOut = 0.
- Build without CONTROLLER_SIX_BUTTON_EN -> scan length 2*PHASE_CYCLES, and buttonsOut[10:8] = 0 even with the 6-button model pressing X/Y/Z.
